// File: rtl/rbm_pkg.sv
// Shared fixed-point constants and the controller state type for the RBM datapath.
package rbm_pkg;

    localparam int          FRAC_BITS = 8;
    localparam logic [15:0] ONE_Q88   = 16'h0100;
    localparam logic [15:0] SAT_MAX   = 16'h7FFF;
    localparam logic [15:0] SAT_MIN   = 16'h8001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_narrow.sv
// Symmetric saturating narrower: clamps a wide signed value to +/-(2^(OUT_W-1)-1).
module sat_narrow #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  acc_in,
    output logic        [OUT_W-1:0] sat_out
);

    localparam logic signed [IN_W-1:0] POS_LIM = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] NEG_LIM = -POS_LIM;

    // Most-negative code is never produced, so a downstream negate cannot overflow.
    always_comb begin
        if (acc_in > POS_LIM) begin
            sat_out = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (acc_in < NEG_LIM) begin
            sat_out = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
        end else begin
            sat_out = acc_in[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/hidden_accumulator.sv
// RBM hidden-unit pre-activation: bias + sum(w_i * v_i), saturated to Q8.8 for the sigmoid stage.
// state | meaning
// IDLE  | waiting for start; no beats accepted, no result offered
// ACCUM | accepting weight/visible beats until N_VISIBLE have been taken
// DONE  | saturated result held on out_sum until the consumer takes it
module hidden_accumulator
    import rbm_pkg::*;
#(
    parameter int input_bitlength = 16,
    parameter int N_VISIBLE       = 16,
    parameter int CNT_W           = $clog2(N_VISIBLE + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [input_bitlength-1:0] bias_in,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [input_bitlength-1:0] weight_in,
    input  logic                       v_bit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [input_bitlength-1:0] out_sum,
    output logic                       busy
);

    localparam int ACC_W = input_bitlength + CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_VISIBLE - 1);

    state_t                      state, state_d;
    logic signed [ACC_W-1:0]     acc, acc_d;
    logic        [CNT_W-1:0]     cnt, cnt_d;
    logic [input_bitlength-1:0]  sum_q, sat_val;
    logic                        load_out;
    logic signed [ACC_W-1:0]     bias_ext, weight_ext;

    assign bias_ext   = ACC_W'(signed'(bias_in));
    assign weight_ext = ACC_W'(signed'(weight_in));

    always_comb begin
        state_d  = state;
        acc_d    = acc;
        cnt_d    = cnt;
        load_out = 1'b0;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_d   = bias_ext;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (v_bit) begin
                            acc_d = acc + weight_ext;
                        end
                        cnt_d = cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            state_d  = DONE;
                            load_out = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        // Handshake and a new start in the same cycle chain jobs without an idle bubble.
                        if (start) begin
                            acc_d   = bias_ext;
                            cnt_d   = '0;
                            state_d = ACCUM;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (input_bitlength)
    ) u_sat (
        .acc_in  (acc_d),
        .sat_out (sat_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sum_q <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            if (load_out) begin
                sum_q <= sat_val;
            end
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = sum_q;

endmodule

// File: tb/tb_hidden_accumulator.sv
// Self-checking bench for hidden_accumulator (N_VISIBLE=4): directed cases plus randomized jobs vs. a reference model.
module tb_hidden_accumulator;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bias_in = '0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] weight_in = '0;
    logic        v_bit = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        busy;

    int checks = 0;
    int errors = 0;

    hidden_accumulator #(
        .input_bitlength (16),
        .N_VISIBLE       (NV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias_in   (bias_in),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight_in (weight_in),
        .v_bit     (v_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the job rules.
    int          m_acc = 0;
    int          m_beats = 0;
    bit          m_collect = 1'b0;
    bit          m_hold = 1'b0;
    logic [15:0] m_out = '0;

    function automatic logic [15:0] sat16(input int a);
        if (a > 32767)  return 16'h7FFF;
        if (a < -32767) return 16'h8001;
        return a[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_beats = 0; m_collect = 0; m_hold = 0; m_out = '0;
        end else if (clear) begin
            m_acc = 0; m_beats = 0; m_collect = 0; m_hold = 0;
        end else if (m_collect) begin
            if (in_valid) begin
                if (v_bit) m_acc = m_acc + int'($signed(weight_in));
                m_beats++;
                if (m_beats == NV) begin
                    m_collect = 0;
                    m_hold    = 1;
                    m_out     = sat16(m_acc);
                end
            end
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 0;
                if (start) begin
                    m_acc = int'($signed(bias_in)); m_beats = 0; m_collect = 1;
                end
            end
        end else if (start) begin
            m_acc = int'($signed(bias_in)); m_beats = 0; m_collect = 1;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (in_ready !== m_collect) begin
            errors++; $display("FAIL in_ready: got %b want %b at %0t", in_ready, m_collect, $time);
        end
        checks++;
        if (out_valid !== m_hold) begin
            errors++; $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_hold, $time);
        end
        checks++;
        if (busy !== (m_collect | m_hold)) begin
            errors++; $display("FAIL busy: got %b want %b at %0t", busy, m_collect | m_hold, $time);
        end
        checks++;
        if (out_sum !== m_out) begin
            errors++; $display("FAIL out_sum: got %h want %h at %0t", out_sum, m_out, $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] b);
        bias_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: no gaps, 1: valid every other cycle, 2: random gaps
    task automatic feed(input logic [NV-1:0][15:0] w, input logic [NV-1:0] v, input int mode,
                        output logic [15:0] res, output int lat);
        int  idx;
        bit  fire;
        idx = 0; lat = 0;
        while (!out_valid && lat < 200) begin
            if (idx < NV) begin
                weight_in = w[idx]; v_bit = v[idx];
                in_valid  = (mode == 0) ? 1'b1 : (mode == 1) ? ~lat[0] : 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk); fire = in_valid && in_ready;
            @(posedge clk); #1;
            lat++;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        chk("result_timeout", {31'd0, out_valid}, 32'd1);
        res = out_sum;
    endtask

    task automatic handshake(input bit chain, input logic [15:0] next_bias);
        out_ready = 1'b1; start = chain; bias_in = next_bias;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
    endtask

    initial begin
        logic [NV-1:0][15:0] w;
        logic [15:0] res, held;
        int lat;
        bit chained;

        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 + 4*0.5 = 3.0
        w = {4{16'h0080}};
        start_job(16'h0100);
        feed(w, 4'b1111, 0, res, lat);
        chk("basic_sum", {16'd0, res}, 32'h0300);
        chk("basic_latency", lat + 1, 5);
        handshake(0, '0);

        w = {16'h0800, 16'h0400, 16'h0200, 16'h0100};
        start_job(16'h0000);
        feed(w, 4'b0101, 0, res, lat);
        chk("mask_sum", {16'd0, res}, 32'h0500);
        handshake(0, '0);

        w = {4{16'h4000}};
        start_job(16'h7000);
        feed(w, 4'b1111, 0, res, lat);
        chk("sat_pos", {16'd0, res}, 32'h7FFF);
        handshake(0, '0);

        w = {4{16'hC000}};
        start_job(16'h9000);
        feed(w, 4'b1111, 0, res, lat);
        chk("sat_neg", {16'd0, res}, 32'h8001);
        held = res;

        // Backpressure: beats and start offered while DONE must be ignored.
        in_valid = 1'b1; weight_in = 16'h7FFF; v_bit = 1'b1; start = 1'b1; bias_in = 16'h1234;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_hold_sum", {16'd0, out_sum}, {16'd0, held});
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; start = 1'b0;
        handshake(1, 16'h0010);
        chk("chain_busy", {31'd0, busy}, 32'd1);
        chk("chain_in_ready", {31'd0, in_ready}, 32'd1);
        w = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        feed(w, 4'b1111, 1, res, lat);
        chk("gap_sum", {16'd0, res}, 32'h001A);
        handshake(0, '0);

        // Abort after two beats.
        start_job(16'h0100);
        weight_in = 16'h0100; v_bit = 1'b1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1; in_valid = 1'b0; clear = 1'b1; start = 1'b1;
        @(posedge clk); #1; clear = 1'b0; start = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
        w = {4{16'h0020}};
        start_job(16'hFFF0);
        feed(w, 4'b1011, 0, res, lat);
        chk("post_clear_sum", {16'd0, res}, 32'h0050);
        handshake(0, '0);

        // Asynchronous reset mid-job.
        start_job(16'h0200);
        weight_in = 16'h0100; v_bit = 1'b1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1; in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_sum", {16'd0, out_sum}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        w = {4{16'h0100}};
        start_job(16'hFF00);
        feed(w, 4'b1111, 0, res, lat);
        chk("post_rst_sum", {16'd0, res}, 32'h0300);
        handshake(0, '0);

        // Randomized jobs: mixed magnitudes, random gaps, random consumer stalls, chaining.
        chained = 1'b0;
        for (int j = 0; j < 40; j++) begin
            logic [15:0] r;
            for (int k = 0; k < NV; k++) begin
                r = 16'($urandom);
                w[k] = ($urandom_range(0, 1) == 1) ? r : {{8{r[7]}}, r[7:0]};
            end
            if (!chained) start_job(16'($urandom));
            feed(w, 4'($urandom), 2, res, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chained = 1'($urandom_range(0, 1));
            handshake(chained, 16'($urandom));
        end
        if (chained) begin
            w = '0;
            feed(w, 4'b0000, 0, res, lat);
            handshake(0, '0);
        end
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hidden_accumulator.md
Name: hidden_accumulator

Overview:
- Computes the pre-activation sum of one RBM hidden unit: bias + Σ w_i·v_i, where v_i ∈ {0,1} are visible-unit states.
- Weights and visible bits stream in one beat per cycle. The saturated 16-bit signed result is presented with valid/ready.
- Sits directly upstream of the sigmoid stage. out_sum drives the sigmoid's `sum` input unchanged (Q8.8 two's complement, 1.0 = 0x0100).

Parameters:
- input_bitlength, 16, width of bias, weights and out_sum (Q8.8 two's complement).
- N_VISIBLE, 16, number of weight/visible beats per job (≥1).
- CNT_W, $clog2(N_VISIBLE+1), beat counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin job; accepted per rules below.
- bias_in  in  input_bitlength  unit bias, sampled on start acceptance.
- clear  in  1  synchronous abort; returns to IDLE.
- in_valid  in  1  weight beat valid.
- in_ready  out  1  block accepts a beat.
- weight_in  in  input_bitlength  w_i, signed Q8.8.
- v_bit  in  1  visible state v_i.
- out_valid  out  1  out_sum valid.
- out_ready  in  1  consumer accepts out_sum.
- out_sum  out  input_bitlength  saturated sum.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- One clock, reset asynchronous and active-low. On rst_n=0:
  - state=IDLE, acc=0, cnt=0.
  - in_ready=0, out_valid=0, out_sum=0, busy=0.
- Accumulator acc is ACC_W = input_bitlength+CNT_W+1 bits signed. No internal overflow is possible.
- States:
  - IDLE: in_ready=0, out_valid=0. On start=1: acc ← sign-extended bias_in, cnt ← 0, go to ACCUM.
  - ACCUM: in_ready=1. On a beat (in_valid & in_ready):
    - if v_bit=1, acc ← acc + sign-extended weight_in; if v_bit=0, acc unchanged.
    - cnt ← cnt+1.
    - When the beat with cnt==N_VISIBLE-1 is accepted, go to DONE.
    - in_valid gaps are allowed; cnt advances only on beats.
  - DONE: in_ready=0, out_valid=1. out_sum is registered, saturated acc, and stays stable until the handshake. On out_valid & out_ready: go to IDLE.
- Back-to-back jobs: start asserted in DONE in the same cycle as the out handshake is accepted. acc/cnt reload and the block goes straight to ACCUM. start is ignored in ACCUM, and in DONE without out_ready.
- Saturation, applied when entering DONE:
  - acc > 0x7FFF → 0x7FFF.
  - acc < −0x7FFF → 0x8001 (symmetric clamp, so negation downstream never overflows).
  - otherwise acc[input_bitlength-1:0].
- Latency: out_valid rises on the clock edge after the N_VISIBLE-th accepted beat. With no gaps, a job takes N_VISIBLE+1 cycles from start to out_valid.
- clear=1: next state IDLE, out_valid/in_ready/busy=0 next cycle, acc/cnt cleared. clear has priority over start and beats in the same cycle.
- Beats presented while in_ready=0 are not consumed. The upstream must hold them, per standard valid/ready.
- out_sum holds its last value in IDLE/ACCUM. Only out_valid qualifies it.
- rst_n asserted mid-job: immediate return to reset values. No partial result is emitted.

Decomposition:
- Shared package rbm_pkg: fixed-point constants FRAC_BITS=8, ONE_Q88=16'h0100, SAT_MAX=16'h7FFF, SAT_MIN=16'h8001; state enum {IDLE, ACCUM, DONE}.
- One sub-module: sat_narrow (combinational ACC_W→input_bitlength symmetric saturator). It is reusable for other accumulators in the design.

Test Plan:
- N_VISIBLE=4, bias 0x0100, weights 0x0080×4, v_bit all 1, no gaps → out_valid 5 cycles after start, out_sum=0x0300.
- Mask check: bias 0, weights 0x0100/0x0200/0x0400/0x0800, v_bits 1,0,1,0 → out_sum=0x0500; then with sigmoid attached, s=0xFF boundary behaviour.
- Saturation: bias 0x7000, weights 0x4000×4 all v=1 → 0x7FFF; bias 0x9000, weights 0xC000×4 → 0x8001.
- Backpressure: out_ready low 6 cycles in DONE → out_sum stable, in_ready=0, in_valid beats not consumed, start ignored; out_ready=1 with start=1 → new job accepted same cycle, busy stays 1.
- Gaps and abort: in_valid toggled every other cycle → correct sum after 4 beats; clear after 2 beats → IDLE next cycle, no out_valid, subsequent job result correct.
- Reset mid-job: rst_n low after 2 beats → all outputs 0 asynchronously; after release, a fresh job (bias 0xFF00, weights 0x0100×4) → 0x0300.
